// File: rtl/square_gen_multi.sv
// Multi-channel BCD-programmed rectangular-wave generator. One shared sequential
// engine turns a BCD frequency into a period/high-time pair; each channel applies it at a period boundary.
module square_gen_multi #(
  parameter int CHANNELS   = 4,
  parameter int FOSC_HZ    = 50000000,
  parameter int BCD_DIGITS = 6,
  parameter int CNT_W      = 32,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CW-1:0]           cfg_chan,
  input  logic [4*BCD_DIGITS-1:0] cfg_freq_bcd,
  input  logic [7:0]              cfg_duty,
  output logic                    cfg_done,
  output logic                    cfg_err,
  input  logic [CHANNELS-1:0]     chan_en,
  output logic [CHANNELS-1:0]     wave,
  output logic [CHANNELS-1:0]     sync
);

  localparam int FW = 4 * BCD_DIGITS;
  localparam int SW = $clog2((CNT_W > BCD_DIGITS ? CNT_W : BCD_DIGITS) + 1);
  localparam int PW = CNT_W + 8;

  typedef enum logic [2:0] {S_IDLE, S_BCD, S_CHECK, S_DIV, S_SCALE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [FW-1:0]   bcd_q, bcd_d;
  logic [FW-1:0]   f_q, f_d;
  logic            bad_q, bad_d;
  logic            err_q, err_d;
  logic [FW-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [7:0]      duty_q, duty_d;

  logic [3:0]      digit;
  logic [FW:0]     rem_sh;
  logic            sub;
  logic            eng_commit;

  // Handshake: a request is taken on the cycle cfg_valid && cfg_ready; cfg_ready is
  // low from the next cycle until the cfg_done pulse, and cfg_valid is ignored meanwhile.
  assign cfg_ready  = (state_q == S_IDLE);
  assign cfg_done   = (state_q == S_DONE);
  assign cfg_err    = (state_q == S_DONE) && err_q;
  assign eng_commit = (state_q == S_DONE) && !err_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    bcd_d   = bcd_q;
    f_d     = f_q;
    bad_d   = bad_q;
    err_d   = err_q;
    rem_d   = rem_q;
    num_d   = num_q;
    h_d     = h_q;
    chan_d  = chan_q;
    duty_d  = duty_q;
    digit   = bcd_q[FW-1 -: 4];
    rem_sh  = {rem_q, num_q[CNT_W-1]};
    sub     = (rem_sh >= {1'b0, f_q});
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          chan_d  = cfg_chan;
          duty_d  = cfg_duty;
          bcd_d   = cfg_freq_bcd;
          f_d     = '0;
          bad_d   = 1'b0;
          err_d   = 1'b0;
          step_d  = '0;
          state_d = S_BCD;
        end
      end
      S_BCD: begin
        if (digit > 4'd9) bad_d = 1'b1;
        f_d    = (f_q << 3) + (f_q << 1) + FW'(digit);
        bcd_d  = bcd_q << 4;
        step_d = step_q + SW'(1);
        if (step_q == SW'(BCD_DIGITS - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        step_d = '0;
        rem_d  = '0;
        num_d  = CNT_W'(FOSC_HZ);
        // F above half the clock would give a period shorter than 2 cycles.
        if (bad_q || (f_q == '0) || (64'(f_q) > 64'(FOSC_HZ / 2)) ||
            (32'(chan_q) >= 32'(CHANNELS))) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Restoring division; num_q holds the dividend and collects the quotient.
        num_d  = {num_q[CNT_W-2:0], sub};
        rem_d  = sub ? FW'(rem_sh - {1'b0, f_q}) : rem_sh[FW-1:0];
        step_d = step_q + SW'(1);
        if (step_q == SW'(CNT_W - 1)) state_d = S_SCALE;
      end
      S_SCALE: begin
        h_d     = CNT_W'((PW'(num_q) * PW'(duty_q)) >> 8);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      bcd_q   <= '0;
      f_q     <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      num_q   <= '0;
      h_q     <= '0;
      chan_q  <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      bcd_q   <= bcd_d;
      f_q     <= f_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      h_q     <= h_d;
      chan_q  <= chan_d;
      duty_q  <= duty_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [CNT_W-1:0] p_act_q, p_act_d, h_act_q, h_act_d;
    logic [CNT_W-1:0] p_sh_q, p_sh_d, h_sh_q, h_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d, run_q, run_d;
    logic             wave_q, wave_d, sync_q, sync_d;
    logic             commit, run, wrap, xfer;

    always_comb begin
      commit  = eng_commit && (chan_q == CW'(c));
      run     = chan_en[c] && (p_act_q >= CNT_W'(2));
      wrap    = run && run_q && (cnt_q == p_act_q - CNT_W'(1));
      // Shadow moves to active only at a period boundary or while the channel is idle.
      xfer    = pend_q && (wrap || !chan_en[c] || (p_act_q == '0));
      p_act_d = xfer ? p_sh_q : p_act_q;
      h_act_d = xfer ? h_sh_q : h_act_q;
      p_sh_d  = commit ? num_q : p_sh_q;
      h_sh_d  = commit ? h_q : h_sh_q;
      pend_d  = commit || (pend_q && !xfer);
      run_d   = run;
      cnt_d   = '0;
      wave_d  = 1'b0;
      sync_d  = 1'b0;
      if (run) begin
        if (!run_q || wrap) begin
          cnt_d  = '0;
          sync_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        wave_d = (cnt_d < h_act_d);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        p_act_q <= '0;
        h_act_q <= '0;
        p_sh_q  <= '0;
        h_sh_q  <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        run_q   <= 1'b0;
        wave_q  <= 1'b0;
        sync_q  <= 1'b0;
      end else begin
        p_act_q <= p_act_d;
        h_act_q <= h_act_d;
        p_sh_q  <= p_sh_d;
        h_sh_q  <= h_sh_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        run_q   <= run_d;
        wave_q  <= wave_d;
        sync_q  <= sync_d;
      end
    end

    assign wave[c] = wave_q;
    assign sync[c] = sync_q;
  end

endmodule
